// File: rtl/ipif_arbiter.sv
// Two-port round-robin arbiter sharing one downstream register-file wr/rd request/ack interface.
// Optional ack watchdog is enabled by defining IPIF_ARB_TIMEOUT_EN.
module ipif_arbiter #(
  parameter int C_ADDR_WIDTH = 12,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_TIMEOUT    = 255
) (
  input  logic                          aclk,
  input  logic                          rst,
  input  logic [2*(C_ADDR_WIDTH-2)-1:0] s_wr_addr,
  input  logic [1:0]                    s_wr_req,
  input  logic [7:0]                    s_wr_be,
  input  logic [2*C_DATA_WIDTH-1:0]     s_wr_data,
  output logic [1:0]                    s_wr_ack,
  input  logic [2*(C_ADDR_WIDTH-2)-1:0] s_rd_addr,
  input  logic [1:0]                    s_rd_req,
  output logic [C_DATA_WIDTH-1:0]       s_rd_data,
  output logic [1:0]                    s_rd_ack,
  output logic [C_ADDR_WIDTH-3:0]       m_wr_addr,
  output logic                          m_wr_req,
  output logic [3:0]                    m_wr_be,
  output logic [C_DATA_WIDTH-1:0]       m_wr_data,
  input  logic                          m_wr_ack,
  output logic [C_ADDR_WIDTH-3:0]       m_rd_addr,
  output logic                          m_rd_req,
  input  logic [C_DATA_WIDTH-1:0]       m_rd_data,
  input  logic                          m_rd_ack,
  output logic                          timeout
);

  localparam int AW = C_ADDR_WIDTH - 2;
  localparam int DW = C_DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state, state_nxt;

  logic [1:0]    wr_pend, rd_pend;
  logic [AW-1:0] wr_addr_q [2];
  logic [3:0]    wr_be_q   [2];
  logic [DW-1:0] wr_data_q [2];
  logic [AW-1:0] rd_addr_q [2];

  logic gnt_port, gnt_wr, last_port;
  logic any_pend, sel_port, sel_wr;
  logic ack_hit, tmo_hit, done;

  // Tie goes to the port that was not granted last; writes beat reads within a port.
  assign any_pend = |wr_pend || |rd_pend;
  assign sel_port = ((wr_pend[0] || rd_pend[0]) && (wr_pend[1] || rd_pend[1])) ? ~last_port
                                                                               : (wr_pend[1] || rd_pend[1]);
  assign sel_wr   = wr_pend[sel_port];

  assign ack_hit  = gnt_wr ? m_wr_ack : m_rd_ack;
  assign done     = (state == WAIT) && (ack_hit || tmo_hit);

  always_ff @(posedge aclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    m_wr_req  = 1'b0;
    m_rd_req  = 1'b0;
    s_wr_ack  = 2'b00;
    s_rd_ack  = 2'b00;
    case (state)
      IDLE:  if (any_pend) state_nxt = ISSUE;
      ISSUE: begin
        m_wr_req  = gnt_wr;
        m_rd_req  = !gnt_wr;
        state_nxt = WAIT;
      end
      WAIT:  if (done) state_nxt = RESP;
      RESP: begin
        s_wr_ack[gnt_port] = gnt_wr;
        s_rd_ack[gnt_port] = !gnt_wr;
        state_nxt          = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A new request wins over the clear of its own slot in the same cycle.
  always_ff @(posedge aclk) begin
    if (rst) begin
      wr_pend   <= 2'b00;
      rd_pend   <= 2'b00;
      gnt_port  <= 1'b0;
      gnt_wr    <= 1'b0;
      last_port <= 1'b1;
      m_wr_addr <= '0;
      m_wr_be   <= '0;
      m_wr_data <= '0;
      m_rd_addr <= '0;
      s_rd_data <= '0;
      for (int i = 0; i < 2; i++) begin
        wr_addr_q[i] <= '0;
        wr_be_q[i]   <= '0;
        wr_data_q[i] <= '0;
        rd_addr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s_wr_req[i]) begin
          wr_addr_q[i] <= s_wr_addr[i*AW +: AW];
          wr_be_q[i]   <= s_wr_be[i*4 +: 4];
          wr_data_q[i] <= s_wr_data[i*DW +: DW];
          wr_pend[i]   <= 1'b1;
        end else if (done && gnt_wr && (gnt_port == 1'(i))) begin
          wr_pend[i]   <= 1'b0;
        end
        if (s_rd_req[i]) begin
          rd_addr_q[i] <= s_rd_addr[i*AW +: AW];
          rd_pend[i]   <= 1'b1;
        end else if (done && !gnt_wr && (gnt_port == 1'(i))) begin
          rd_pend[i]   <= 1'b0;
        end
      end
      if ((state == IDLE) && any_pend) begin
        gnt_port  <= sel_port;
        gnt_wr    <= sel_wr;
        last_port <= sel_port;
        if (sel_wr) begin
          m_wr_addr <= wr_addr_q[sel_port];
          m_wr_be   <= wr_be_q[sel_port];
          m_wr_data <= wr_data_q[sel_port];
        end else begin
          m_rd_addr <= rd_addr_q[sel_port];
        end
      end
      if (done && !gnt_wr) s_rd_data <= tmo_hit ? '1 : m_rd_data;
    end
  end

`ifdef IPIF_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        tmo_q;

  // Counter is zero in the first WAIT cycle, so the limit hits on the C_TIMEOUT-th WAIT cycle.
  always_ff @(posedge aclk) begin
    if (rst) begin
      wait_cnt <= '0;
      tmo_q    <= 1'b0;
    end else begin
      if (state == ISSUE)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 16'd1;
      if (done) tmo_q <= tmo_hit;
    end
  end

  assign tmo_hit = (state == WAIT) && !ack_hit && (wait_cnt == 16'(C_TIMEOUT - 1));
  assign timeout = (state == RESP) && tmo_q;
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule
